br_flow_buf_bypass: RTL and testbench
=====================================

# br_flow_buf_bypass

Multi-entry bypass flow buffer: a Depth-entry FIFO with ready-valid on both sides that forwards push data combinationally to pop when empty and the consumer is ready (0-cycle cut-through). It generalises the single-entry bypass flow register to arbitrary depth. It adds an optional registered-ready mode that breaks the pop_ready→push_ready path. It sits between pipeline stages that need zero-latency forwarding plus absorption of multi-cycle consumer stalls.

## Interface
- Width, default 1: payload bits; must be ≥ 1.
- Depth, default 2: storage entries; must be ≥ 1; non-power-of-2 allowed.
- RegisterPushReady, default 0:
  - 0: push_ready = pop_ready || !full (combinational path from pop_ready).
  - 1: push_ready = !full (registered-only).
- EnableAssertPushValidStability, default 1: assert push_valid is held while backpressured.
- EnableAssertPushDataStability, default 1: assert push_data is held while backpressured.
- EnableAssertFinalNotValid, default 1: assert no valid is pending at end of test.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push_ready  out  1  buffer accepts push this cycle.
- push_valid  in  1  push request.
- push_data  in  Width  push payload.
- pop_ready  in  1  consumer accepts.
- pop_valid  out  1  pop payload valid.
- pop_data  out  Width  pop payload.
- items  out  CountWidth = $clog2(Depth+1)  entries currently stored (excludes bypassed data).
- full  out  1  items == Depth.
- empty  out  1  items == 0.

## Operation
- pushed = push_valid && push_ready; popped = pop_valid && pop_ready.
- Bypass: when empty && pop_ready && push_valid:
  - pop_data = push_data; nothing stored.
  - items and pointers unchanged.
- Store: a push is written at wr_ptr when pushed && !(empty && pop_ready).
- Pop from storage: when !empty, pop_valid = 1 and pop_data = mem[rd_ptr]. When empty, pop_valid = push_valid and pop_data = push_data.
- Buffer pop: !empty && pop_ready; advances rd_ptr.
- Items update: items_next = items + store − buffer_pop. Simultaneous store and buffer pop leaves items unchanged.
- Full with pop_ready (RegisterPushReady=0):
  - push accepted; the head entry is read combinationally this cycle.
  - new data is written to the freed slot at the clock edge (wr_ptr == rd_ptr).
  - ordering is strictly FIFO.
- Pointers: range 0..Depth−1; increment wraps Depth−1 → 0.
- Storage data is not reset; it is qualified by items.
- Stability: pop_valid never falls without a pop. pop_data is stable while pop_valid && !pop_ready, provided the push side obeys stability.

## Timing
- Reset values: items = 0, empty = 1, full = 0, rd_ptr = wr_ptr = 0, push_ready = 1.
- During reset, pop_valid = push_valid and pop_data = push_data.
- Reset asserted mid-operation discards all stored entries at the next edge.
- Cut-through latency is 0 cycles when empty and pop_ready. Otherwise data appears at the head after stored predecessors drain, at 1 entry per cycle.
- Backpressure latency:
  - RegisterPushReady=0: 0 cycles.
  - RegisterPushReady=1: 1 cycle (push_ready rises the cycle after a pop from full).
- Throughput is 1 transaction per cycle at steady state, full or empty.
- Depth=1, RegisterPushReady=0: behaviour is identical to a 1-entry bypass flow register.

## Structure
- Package br_flow_buf_pkg: function count_width(Depth) returning $clog2(Depth+1). No typedefs needed.
- Sub-module br_flow_buf_wrap_ptr: parametrised by Depth, with inputs incr and rst and output ptr. Two instances, one for read and one for write.
- Storage is a flop array, Depth × Width, with a write enable per entry.
- Integration checks use br_flow_checks_valid_data_intg on push. Implementation checks use br_flow_checks_valid_data_impl on pop.
- Implementation assertions:
  - empty |-> !(full).
  - push_valid |-> pop_valid.
  - RegisterPushReady == 0 && pop_ready |-> push_ready.

## Test plan
- Bypass: Depth=4, pop_ready=1 always; push 0x1..0x8 back-to-back → each pop_data equals push_data in the same cycle; items stays 0.
- Fill/drain: Depth=4, pop_ready=0; push 0xA,0xB,0xC,0xD → items 1,2,3,4, full=1, push_ready=0. Then pop_ready=1 → pops 0xA..0xD in order, one per cycle, and empty=1 after.
- Full with simultaneous push/pop:
  - RegisterPushReady=0, full: push 0xE with pop_ready=1 → pop 0xA that cycle, items stays 4, sequence continues 0xB,0xC,0xD,0xE.
  - RegisterPushReady=1: push_ready stays 0 that cycle.
- Wrap-around: Depth=3, random valid/ready for 1000 cycles vs a scoreboard → no loss or reorder; pointers wrap 2→0.
- Reset mid-operation: items=2, assert rst for one cycle → next cycle items=0, empty=1, and pop_valid tracks push_valid only.
- Depth=1, RegisterPushReady=0: cycle-equivalent to a single-entry bypass flow register under random stimulus.

Source files
------------

// File: rtl/br_flow_buf_pkg.sv
// Shared helpers for the bypass flow buffer.
// Provides counter and pointer width calculations.
package br_flow_buf_pkg;

    // Width needed to count 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a pointer that indexes 0..depth-1 (never zero bits).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/br_flow_buf_wrap_ptr.sv
// Wrapping pointer that counts 0..Depth-1 and then returns to 0.
// Ports: clk, rst (sync active-high), incr (advance), ptr (current value).
module br_flow_buf_wrap_ptr
    import br_flow_buf_pkg::*;
#(
    parameter int Depth = 2,
    localparam int PtrWidth = ptr_width(Depth)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                incr,
    output logic [PtrWidth-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (incr) begin
            if (ptr == PtrWidth'(Depth - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PtrWidth'(1);
            end
        end
    end

endmodule

// File: rtl/br_flow_buf_bypass.sv
// Multi-entry FIFO with ready/valid on both sides and 0-cycle cut-through when empty.
// Ports: clk, rst; push_ready/push_valid/push_data; pop_ready/pop_valid/pop_data;
//        items (stored entries, bypassed data excluded), full, empty.
module br_flow_buf_bypass
    import br_flow_buf_pkg::*;
#(
    parameter int Width = 1,
    parameter int Depth = 2,
    parameter bit RegisterPushReady = 1'b0,
    parameter bit EnableAssertPushValidStability = 1'b1,
    parameter bit EnableAssertPushDataStability = 1'b1,
    parameter bit EnableAssertFinalNotValid = 1'b1,
    localparam int CountWidth = count_width(Depth),
    localparam int PtrWidth = ptr_width(Depth)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  push_ready,
    input  logic                  push_valid,
    input  logic [Width-1:0]      push_data,
    input  logic                  pop_ready,
    output logic                  pop_valid,
    output logic [Width-1:0]      pop_data,
    output logic [CountWidth-1:0] items,
    output logic                  full,
    output logic                  empty
);

    logic [Width-1:0]    mem [Depth];
    logic [Width-1:0]    head;
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr;
    logic                store;
    logic                buf_pop;

    assign empty = (items == '0);
    assign full  = (items == CountWidth'(Depth));

    // With a registered ready the consumer's ready cannot reopen a full buffer
    // in the same cycle; the slot shows up one cycle after the pop.
    assign push_ready = RegisterPushReady ? !full : (pop_ready || !full);

    // An empty buffer with a ready consumer forwards instead of storing.
    assign store   = push_valid && push_ready && !(empty && pop_ready);
    assign buf_pop = !empty && pop_ready;

    assign pop_valid = !empty || push_valid;
    assign pop_data  = empty ? push_data : head;

    br_flow_buf_wrap_ptr #(.Depth(Depth)) u_rd_ptr (
        .clk  (clk),
        .rst  (rst),
        .incr (buf_pop),
        .ptr  (rd_ptr)
    );

    br_flow_buf_wrap_ptr #(.Depth(Depth)) u_wr_ptr (
        .clk  (clk),
        .rst  (rst),
        .incr (store),
        .ptr  (wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            items <= '0;
        end else if (store && !buf_pop) begin
            items <= items + CountWidth'(1);
        end else if (!store && buf_pop) begin
            items <= items - CountWidth'(1);
        end
    end

    // Payload storage is not reset; items qualifies what is meaningful.
    // When full with a pop, wr_ptr == rd_ptr: the head is read now and
    // the slot is overwritten at the edge.
    for (genvar i = 0; i < Depth; i++) begin : g_mem
        logic we;
        assign we = store && (wr_ptr == PtrWidth'(i));
        always_ff @(posedge clk) begin
            if (we) begin
                mem[i] <= push_data;
            end
        end
    end

    if (Depth == 1) begin : g_head_one
        assign head = mem[0];
    end else begin : g_head_many
        assign head = mem[rd_ptr];
    end

    if (EnableAssertPushValidStability) begin : g_a_pv
        a_push_valid_held: assert property (@(posedge clk) disable iff (rst)
            push_valid && !push_ready |=> push_valid);
    end

    if (EnableAssertPushDataStability) begin : g_a_pd
        a_push_data_held: assert property (@(posedge clk) disable iff (rst)
            push_valid && !push_ready |=> $stable(push_data));
    end

    a_pop_held: assert property (@(posedge clk) disable iff (rst)
        pop_valid && !pop_ready |=> pop_valid && $stable(pop_data));

    a_empty_not_full: assert property (@(posedge clk) disable iff (rst)
        empty |-> !full);

    a_push_implies_pop: assert property (@(posedge clk) disable iff (rst)
        push_valid |-> pop_valid);

    if (!RegisterPushReady) begin : g_a_ready
        a_ready_path: assert property (@(posedge clk) disable iff (rst)
            pop_ready |-> push_ready);
    end

    if (EnableAssertFinalNotValid) begin : g_a_final
        final begin
            a_final_idle: assert (!pop_valid);
        end
    end

endmodule

// File: tb/tb_br_flow_buf_bypass.sv
// Testbench for br_flow_buf_bypass: directed vector tables on Depth=4 instances
// and random stimulus against a queue model on Depth=3 and Depth=1 instances.
module tb_br_flow_buf_bypass;

    typedef struct {
        logic       rst;
        logic       pv;
        logic [7:0] pd;
        logic       pr;
        logic       prdy;
        logic       pvld;
        logic [7:0] pdat;
        int         items;
        logic       full;
        logic       empty;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Depth 4, combinational ready
    logic       rst4 = 1'b1, pv4 = 1'b0, pr4 = 1'b0;
    logic [7:0] pd4 = '0, pdat4;
    logic       prdy4, pvld4, full4, empty4;
    logic [2:0] items4;

    // Depth 4, registered ready
    logic       rstr = 1'b1, pvr = 1'b0, prr = 1'b0;
    logic [7:0] pdr = '0, pdatr;
    logic       prdyr, pvldr, fullr, emptyr;
    logic [2:0] itemsr;

    // Depth 3, random
    logic       rst3 = 1'b1, pv3 = 1'b0, pr3 = 1'b0;
    logic [7:0] pd3 = '0, pdat3;
    logic       prdy3, pvld3, full3, empty3;
    logic [1:0] items3;

    // Depth 1, random
    logic       rst1 = 1'b1, pv1 = 1'b0, pr1 = 1'b0;
    logic [7:0] pd1 = '0, pdat1;
    logic       prdy1, pvld1, full1, empty1;
    logic [0:0] items1;

    br_flow_buf_bypass #(.Width(8), .Depth(4), .RegisterPushReady(1'b0)) u_d4 (
        .clk(clk), .rst(rst4), .push_ready(prdy4), .push_valid(pv4),
        .push_data(pd4), .pop_ready(pr4), .pop_valid(pvld4), .pop_data(pdat4),
        .items(items4), .full(full4), .empty(empty4));

    br_flow_buf_bypass #(.Width(8), .Depth(4), .RegisterPushReady(1'b1)) u_d4r (
        .clk(clk), .rst(rstr), .push_ready(prdyr), .push_valid(pvr),
        .push_data(pdr), .pop_ready(prr), .pop_valid(pvldr), .pop_data(pdatr),
        .items(itemsr), .full(fullr), .empty(emptyr));

    br_flow_buf_bypass #(.Width(8), .Depth(3), .RegisterPushReady(1'b0)) u_d3 (
        .clk(clk), .rst(rst3), .push_ready(prdy3), .push_valid(pv3),
        .push_data(pd3), .pop_ready(pr3), .pop_valid(pvld3), .pop_data(pdat3),
        .items(items3), .full(full3), .empty(empty3));

    br_flow_buf_bypass #(.Width(8), .Depth(1), .RegisterPushReady(1'b0)) u_d1 (
        .clk(clk), .rst(rst1), .push_ready(prdy1), .push_valid(pv1),
        .push_data(pd1), .pop_ready(pr1), .pop_valid(pvld1), .pop_data(pdat1),
        .items(items1), .full(full1), .empty(empty1));

    function automatic vec_t row(input logic rst, pv, input logic [7:0] pd,
                                 input logic pr, prdy, pvld,
                                 input logic [7:0] pdat, input int items,
                                 input logic full, empty);
        vec_t v;
        v.rst = rst; v.pv = pv; v.pd = pd; v.pr = pr;
        v.prdy = prdy; v.pvld = pvld; v.pdat = pdat;
        v.items = items; v.full = full; v.empty = empty;
        return v;
    endfunction

    // Reference behaviour from the buffer rules: stored entries form a queue,
    // the head is shown when non-empty, otherwise the push side passes through.
    function automatic vec_t model(input int sz, input logic [7:0] hd,
                                   input int depth, input bit rpr,
                                   input logic pv, input logic [7:0] pd,
                                   input logic pr);
        vec_t e;
        e.rst = 1'b0; e.pv = pv; e.pd = pd; e.pr = pr;
        e.prdy  = rpr ? (sz < depth) : (pr || sz < depth);
        e.pvld  = (sz > 0) || pv;
        e.pdat  = (sz > 0) ? hd : pd;
        e.items = sz;
        e.full  = (sz == depth);
        e.empty = (sz == 0);
        return e;
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic prdy, pvld, input logic [7:0] pdat,
                         input logic [3:0] items, input logic full, empty,
                         input vec_t e);
        bit bad;
        nvec++;
        bad = (prdy !== e.prdy) || (pvld !== e.pvld) ||
              (e.pvld && pdat !== e.pdat) || (items !== 4'(e.items)) ||
              (full !== e.full) || (empty !== e.empty);
        if (bad) begin
            nmis++;
            $display("FAIL %s[%0d]: got prdy=%b pvld=%b data=%h items=%0d full=%b empty=%b; want prdy=%b pvld=%b data=%h items=%0d full=%b empty=%b",
                     nm, idx, prdy, pvld, pdat, items, full, empty,
                     e.prdy, e.pvld, e.pdat, e.items, e.full, e.empty);
        end
    endtask

    vec_t tab4[$];
    vec_t tabr[$];
    logic [7:0] q3[$];
    logic [7:0] q1[$];

    initial begin
        vec_t e;
        bit acc3, acc1, drain;

        // reset and pass-through during reset
        tab4.push_back(row(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));
        tab4.push_back(row(1, 1, 8'h55, 0, 1, 1, 8'h55, 0, 0, 1));
        // bypass with a ready consumer
        for (int i = 1; i <= 8; i++)
            tab4.push_back(row(0, 1, 8'(i), 1, 1, 1, 8'(i), 0, 0, 1));
        // fill
        tab4.push_back(row(0, 1, 8'h0A, 0, 1, 1, 8'h0A, 0, 0, 1));
        tab4.push_back(row(0, 1, 8'h0B, 0, 1, 1, 8'h0A, 1, 0, 0));
        tab4.push_back(row(0, 1, 8'h0C, 0, 1, 1, 8'h0A, 2, 0, 0));
        tab4.push_back(row(0, 1, 8'h0D, 0, 1, 1, 8'h0A, 3, 0, 0));
        tab4.push_back(row(0, 0, 8'h00, 0, 0, 1, 8'h0A, 4, 1, 0));
        // full: push and pop together
        tab4.push_back(row(0, 1, 8'h0E, 1, 1, 1, 8'h0A, 4, 1, 0));
        // drain
        tab4.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h0B, 4, 1, 0));
        tab4.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h0C, 3, 0, 0));
        tab4.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h0D, 2, 0, 0));
        tab4.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h0E, 1, 0, 0));
        tab4.push_back(row(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));
        // reset with two entries stored
        tab4.push_back(row(0, 1, 8'h0F, 0, 1, 1, 8'h0F, 0, 0, 1));
        tab4.push_back(row(0, 1, 8'h10, 0, 1, 1, 8'h0F, 1, 0, 0));
        tab4.push_back(row(1, 0, 8'h00, 0, 1, 1, 8'h0F, 2, 0, 0));
        tab4.push_back(row(0, 1, 8'h33, 0, 1, 1, 8'h33, 0, 0, 1));
        tab4.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 0, 0));
        tab4.push_back(row(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));

        // registered ready: no same-cycle reopen when full
        tabr.push_back(row(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));
        tabr.push_back(row(0, 1, 8'h01, 0, 1, 1, 8'h01, 0, 0, 1));
        tabr.push_back(row(0, 1, 8'h02, 0, 1, 1, 8'h01, 1, 0, 0));
        tabr.push_back(row(0, 1, 8'h03, 0, 1, 1, 8'h01, 2, 0, 0));
        tabr.push_back(row(0, 1, 8'h04, 0, 1, 1, 8'h01, 3, 0, 0));
        tabr.push_back(row(0, 1, 8'h05, 1, 0, 1, 8'h01, 4, 1, 0));
        tabr.push_back(row(0, 1, 8'h05, 1, 1, 1, 8'h02, 3, 0, 0));
        tabr.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h03, 3, 0, 0));
        tabr.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h04, 2, 0, 0));
        tabr.push_back(row(0, 0, 8'h00, 1, 1, 1, 8'h05, 1, 0, 0));
        tabr.push_back(row(0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1));

        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b0;
        rst1 = 1'b0;

        foreach (tab4[i]) begin
            @(posedge clk);
            #1;
            rst4 = tab4[i].rst; pv4 = tab4[i].pv;
            pd4 = tab4[i].pd; pr4 = tab4[i].pr;
            @(negedge clk);
            check("d4", i, prdy4, pvld4, pdat4, {1'b0, items4},
                  full4, empty4, tab4[i]);
        end

        foreach (tabr[i]) begin
            @(posedge clk);
            #1;
            rstr = tabr[i].rst; pvr = tabr[i].pv;
            pdr = tabr[i].pd; prr = tabr[i].pr;
            @(negedge clk);
            check("d4r", i, prdyr, pvldr, pdatr, {1'b0, itemsr},
                  fullr, emptyr, tabr[i]);
        end

        // random traffic; the last cycles drain both buffers
        acc3 = 1'b1;
        acc1 = 1'b1;
        for (int c = 0; c < 1010; c++) begin
            drain = (c >= 1000);
            @(posedge clk);
            #1;
            if (!(pv3 && !acc3)) begin
                pv3 = drain ? 1'b0 : ($urandom_range(3) != 0);
                pd3 = 8'($urandom);
            end
            pr3 = drain ? 1'b1 : 1'($urandom_range(1));
            if (!(pv1 && !acc1)) begin
                pv1 = drain ? 1'b0 : ($urandom_range(3) != 0);
                pd1 = 8'($urandom);
            end
            pr1 = drain ? 1'b1 : 1'($urandom_range(1));
            @(negedge clk);

            e = model(q3.size(), (q3.size() > 0) ? q3[0] : 8'h00,
                      3, 1'b0, pv3, pd3, pr3);
            check("d3", c, prdy3, pvld3, pdat3, {2'b00, items3},
                  full3, empty3, e);
            acc3 = pv3 && e.prdy;
            if (q3.size() == 0) begin
                if (acc3 && !pr3) q3.push_back(pd3);
            end else begin
                if (pr3) void'(q3.pop_front());
                if (acc3) q3.push_back(pd3);
            end

            e = model(q1.size(), (q1.size() > 0) ? q1[0] : 8'h00,
                      1, 1'b0, pv1, pd1, pr1);
            check("d1", c, prdy1, pvld1, pdat1, {3'b000, items1},
                  full1, empty1, e);
            acc1 = pv1 && e.prdy;
            if (q1.size() == 0) begin
                if (acc1 && !pr1) q1.push_back(pd1);
            end else begin
                if (pr1) void'(q1.pop_front());
                if (acc1) q1.push_back(pd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
